// File: rtl/ptt_pkg.sv
// Shared types for the programmable truth-table evaluator.
package ptt_pkg;

  typedef enum logic [1:0] {INIT, CLEAR, RUN} state_e;

  // Entry fields are sized for the widest supported OUT_W; users slice [OUT_W-1:0].
  localparam int ENTRY_MAX_W = 16;

  typedef struct packed {
    logic [ENTRY_MAX_W-1:0] val;
    logic [ENTRY_MAX_W-1:0] care;
  } entry_t;

  localparam entry_t DEFAULT_ENTRY = '{val: '0, care: '0};

endpackage

// File: rtl/ptt_table_ram.sv
// Truth-table storage: one synchronous write port, one asynchronous read port, no reset.
module ptt_table_ram #(
  parameter int AW = 3,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Async read sees the pre-write contents during a same-cycle write.
  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_truth_table.sv
// Run-time programmable truth table: sweep-initialised RAM, config write port,
// and a one-deep registered valid/ready evaluation stage.
module prog_truth_table
  import ptt_pkg::*;
#(
  parameter int   IN_W    = 3,
  parameter int   OUT_W   = 2,
  parameter logic DC_FILL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IN_W-1:0]  cfg_addr,
  input  logic [OUT_W-1:0] cfg_val,
  input  logic [OUT_W-1:0] cfg_care,
  input  logic             clear_req,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_y,
  output logic [OUT_W-1:0] out_dc,
  output logic             busy
);

  localparam int            DEPTH = 2**IN_W;
  localparam logic [IN_W:0] LAST  = (IN_W+1)'(DEPTH-1);

  state_e                 state, state_nxt;
  logic [IN_W:0]          cnt, cnt_nxt;
  logic                   we;
  logic [IN_W-1:0]        waddr;
  logic [2*OUT_W-1:0]     wdata, rdata;
  logic [OUT_W-1:0]       rd_val, rd_care, y_nxt;
  logic                   in_fire;

  ptt_table_ram #(.AW(IN_W), .DW(2*OUT_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (in_vec),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we        = 1'b0;
    waddr     = cfg_addr;
    wdata     = {cfg_care, cfg_val};
    unique case (state)
      INIT, CLEAR: begin
        we    = 1'b1;
        waddr = cnt[IN_W-1:0];
        wdata = {DEFAULT_ENTRY.care[OUT_W-1:0], DEFAULT_ENTRY.val[OUT_W-1:0]};
        if (cnt == LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        // A same-cycle cfg write still lands; the sweep then overwrites it.
        we = cfg_valid;
        if (clear_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign busy      = (state != RUN);
  assign cfg_ready = (state == RUN);
  assign in_ready  = (state == RUN) & (~out_valid | out_ready);
  assign in_fire   = in_valid & in_ready;

  assign rd_val  = rdata[OUT_W-1:0];
  assign rd_care = rdata[2*OUT_W-1:OUT_W];

  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    assign y_nxt[i] = rd_care[i] ? rd_val[i] : DC_FILL;
  end

  // Output stage holds through stalls and through CLEAR until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_dc    <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_y     <= y_nxt;
      out_dc    <= ~rd_care;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
